// File: rtl/mac_host_ctrl_if.sv
// mac_host_ctrl_if
// Bundles every handshake/data signal between the MAC host controller, the
// job requester and the MAC block. clk/rst are kept outside as plain ports.
//
//   job side    : job_val/job_rdy, job_a, job_b,
//                 result_val/result_rdy, result_c, result_err, result_cycles
//   MAC side    : host2block_val/host2block_rdy, a_data_out, b_data_out, a_b_we,
//                 block2host_val/block2host_rdy, c_re, c_data_in
//
// modport master : the controller (mac_host_ctrl)
// modport slave  : the environment (job requester + MAC block)
interface mac_host_ctrl_if #(
    parameter int param_M            = 4,
    parameter int param_K            = 4,
    parameter int param_N            = 4,
    parameter int DATA_WIDTH_INITIAL = 8,
    parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2
) ();
    localparam int A_W = param_M * param_K * DATA_WIDTH_INITIAL;
    localparam int B_W = param_K * param_N * DATA_WIDTH_INITIAL;
    localparam int C_W = param_M * param_N * DATA_WIDTH_FINAL;

    logic           job_val;
    logic           job_rdy;
    logic [A_W-1:0] job_a;
    logic [B_W-1:0] job_b;

    logic           host2block_val;
    logic           host2block_rdy;
    logic [A_W-1:0] a_data_out;
    logic [B_W-1:0] b_data_out;
    logic           a_b_we;

    logic           block2host_val;
    logic           block2host_rdy;
    logic           c_re;
    logic [C_W-1:0] c_data_in;

    logic           result_val;
    logic           result_rdy;
    logic [C_W-1:0] result_c;
    logic           result_err;
    logic [15:0]    result_cycles;

    modport master (
        input  job_val, job_a, job_b, host2block_rdy, block2host_val, c_data_in, result_rdy,
        output job_rdy, host2block_val, a_data_out, b_data_out, a_b_we,
               block2host_rdy, c_re, result_val, result_c, result_err, result_cycles
    );

    modport slave (
        output job_val, job_a, job_b, host2block_rdy, block2host_val, c_data_in, result_rdy,
        input  job_rdy, host2block_val, a_data_out, b_data_out, a_b_we,
               block2host_rdy, c_re, result_val, result_c, result_err, result_cycles
    );
endinterface

// File: rtl/mac_host_ctrl.sv
// mac_host_ctrl
// Host-side sequencer for a matrix MAC block: accepts one job (A, B), writes
// the operands into the MAC memories, hands the block a load request, waits
// for its completion, reads C back and presents it to the requester together
// with an abort flag and the job latency in cycles.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mac_host_ctrl_if.master (job, MAC load/result and response signals)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a job; job_rdy=1
// WRITE   | one-cycle a_b_we pulse with the latched A/B
// REQ     | host2block_val=1 until host2block_rdy (or timeout)
// WAIT    | waiting for block2host_val (or timeout)
// READ    | one-cycle c_re pulse
// CAPTURE | C arrives (1-cycle read latency), block2host_rdy=1
// RESP    | result_val=1 until result_rdy
module mac_host_ctrl #(
    parameter int param_M            = 4,
    parameter int param_K            = 4,
    parameter int param_N            = 4,
    parameter int DATA_WIDTH_INITIAL = 8,
    parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    mac_host_ctrl_if.master  bus
);
    localparam int A_W    = param_M * param_K * DATA_WIDTH_INITIAL;
    localparam int B_W    = param_K * param_N * DATA_WIDTH_INITIAL;
    localparam int C_W    = param_M * param_N * DATA_WIDTH_FINAL;
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        REQ     = 3'd2,
        WAIT    = 3'd3,
        READ    = 3'd4,
        CAPTURE = 3'd5,
        RESP    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [15:0]        cyc_q, cyc_d;
    logic [A_W-1:0]     a_q, a_d;
    logic [B_W-1:0]     b_q, b_d;
    logic [C_W-1:0]     c_q, c_d;
    logic               err_q, err_d;

    logic               job_rdy_q, job_rdy_d;
    logic               h2b_val_q, h2b_val_d;
    logic               we_q, we_d;
    logic               b2h_rdy_q, b2h_rdy_d;
    logic               c_re_q, c_re_d;
    logic               res_val_q, res_val_d;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        cyc_d   = cyc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = err_q;

        // Latency counts every cycle between accept and RESP entry, saturating.
        if ((state_q != IDLE) && (state_q != RESP) && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.job_val && job_rdy_q) begin
                    a_d     = bus.job_a;
                    b_d     = bus.job_b;
                    cyc_d   = 16'd0;
                    err_d   = 1'b0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wcnt_d  = '0;
                state_d = REQ;
            end
            REQ: begin
                // Exit condition is tested first so it beats a same-cycle timeout.
                if (bus.host2block_rdy) begin
                    wcnt_d  = '0;
                    state_d = WAIT;
                end else if (wcnt_q == WCNT_LAST) begin
                    err_d   = 1'b1;
                    c_d     = '0;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            WAIT: begin
                if (bus.block2host_val) begin
                    state_d = READ;
                end else if (wcnt_q == WCNT_LAST) begin
                    err_d   = 1'b1;
                    c_d     = '0;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                c_d     = bus.c_data_in;
                state_d = RESP;
            end
            RESP: begin
                if (bus.result_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are a function of the next state only, then registered.
        job_rdy_d = (state_d == IDLE);
        we_d      = (state_d == WRITE);
        h2b_val_d = (state_d == REQ);
        c_re_d    = (state_d == READ);
        b2h_rdy_d = (state_d == CAPTURE);
        res_val_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            cyc_q     <= 16'd0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            err_q     <= 1'b0;
            job_rdy_q <= 1'b1;
            we_q      <= 1'b0;
            h2b_val_q <= 1'b0;
            c_re_q    <= 1'b0;
            b2h_rdy_q <= 1'b0;
            res_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            cyc_q     <= cyc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            err_q     <= err_d;
            job_rdy_q <= job_rdy_d;
            we_q      <= we_d;
            h2b_val_q <= h2b_val_d;
            c_re_q    <= c_re_d;
            b2h_rdy_q <= b2h_rdy_d;
            res_val_q <= res_val_d;
        end
    end

    assign bus.job_rdy        = job_rdy_q;
    assign bus.a_b_we         = we_q;
    assign bus.a_data_out     = a_q;
    assign bus.b_data_out     = b_q;
    assign bus.host2block_val = h2b_val_q;
    assign bus.c_re           = c_re_q;
    assign bus.block2host_rdy = b2h_rdy_q;
    assign bus.result_val     = res_val_q;
    assign bus.result_c       = c_q;
    assign bus.result_err     = err_q;
    // Only advances before RESP, so it is stable while result_val is high.
    assign bus.result_cycles  = cyc_q;

endmodule

// File: tb/tb_mac_host_ctrl.sv
module tb_mac_host_ctrl;
    localparam int AW = 128;
    localparam int BW = 128;
    localparam int CW = 256;

    // Identity A, B = 1..16, expected C = B zero-extended to 16-bit elements.
    localparam logic [AW-1:0] A_ID  = 128'h01000000000100000000010000000001;
    localparam logic [BW-1:0] B_SEQ = 128'h100f0e0d0c0b0a090807060504030201;
    localparam logic [CW-1:0] C_SEQ = 256'h0010000f000e000d000c000b000a00090008000700060005000400030002_0001;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mac_host_ctrl_if b1 ();
    mac_host_ctrl_if b2 ();

    mac_host_ctrl dut1 (.clk(clk), .rst(rst), .bus(b1.master));
    mac_host_ctrl #(.TIMEOUT_CYCLES(8)) dut2 (.clk(clk), .rst(rst), .bus(b2.master));

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk1({tag, "_job_rdy1"}, b1.job_rdy, 1'b1);
        chk1({tag, "_job_rdy2"}, b2.job_rdy, 1'b1);
        chk1({tag, "_h2b_val"},  b2.host2block_val, 1'b0);
        chk1({tag, "_we"},       b2.a_b_we, 1'b0);
        chk1({tag, "_b2h_rdy"},  b2.block2host_rdy, 1'b0);
        chk1({tag, "_c_re"},     b2.c_re, 1'b0);
        chk1({tag, "_res_val"},  b2.result_val, 1'b0);
        chk1({tag, "_res_err"},  b2.result_err, 1'b0);
        chkw({tag, "_cycles"},   256'(b2.result_cycles), 256'd0);
        chkw({tag, "_res_c"},    256'(b2.result_c), 256'd0);
        chkw({tag, "_a_out"},    256'(b2.a_data_out), 256'd0);
        chkw({tag, "_b_out"},    256'(b2.b_data_out), 256'd0);
        chkw({tag, "_res_c1"},   256'(b1.result_c), 256'd0);
        chkw({tag, "_a_out1"},   256'(b1.a_data_out), 256'd0);
    endtask

    // One job on dut1. Called at a negedge while it is in IDLE; returns at the
    // negedge after the result handshake. r = extra REQ cycles before the MAC
    // raises host2block_rdy, lat = WAIT cycles before block2host_val, bp =
    // cycles of result_rdy backpressure. Latency = WRITE+REQ(1+r)+WAIT(1+lat)
    // +READ+CAPTURE = 5+r+lat cycles.
    task automatic run_job(input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic [CW-1:0] c, input int r, input int lat,
                           input int bp, input bit hold);
        logic [15:0] exp_cyc;
        exp_cyc = 16'(5 + r + lat);
        chk1("idle_job_rdy", b1.job_rdy, 1'b1);
        b1.job_a   = a;
        b1.job_b   = b;
        b1.job_val = 1'b1;
        @(negedge clk);
        chk1("write_we", b1.a_b_we, 1'b1);
        chk1("write_job_rdy", b1.job_rdy, 1'b0);
        chkw("write_a", 256'(b1.a_data_out), 256'(a));
        chkw("write_b", 256'(b1.b_data_out), 256'(b));
        if (hold) begin
            b1.job_a = ~a;
            b1.job_b = ~b;
        end else begin
            b1.job_val = 1'b0;
        end
        @(negedge clk);
        chk1("req_val", b1.host2block_val, 1'b1);
        chk1("req_we_off", b1.a_b_we, 1'b0);
        for (int i = 0; i < r; i++) begin
            @(negedge clk);
            chk1("req_val_hold", b1.host2block_val, 1'b1);
        end
        b1.host2block_rdy = 1'b1;
        @(negedge clk);
        b1.host2block_rdy = 1'b0;
        chk1("wait_val_low", b1.host2block_val, 1'b0);
        for (int i = 0; i < lat; i++) @(negedge clk);
        chk1("wait_no_re", b1.c_re, 1'b0);
        b1.block2host_val = 1'b1;
        @(negedge clk);
        b1.block2host_val = 1'b0;
        chk1("read_re", b1.c_re, 1'b1);
        chk1("read_ack_low", b1.block2host_rdy, 1'b0);
        b1.c_data_in = c;
        @(negedge clk);
        chk1("cap_re_off", b1.c_re, 1'b0);
        chk1("cap_ack", b1.block2host_rdy, 1'b1);
        chk1("cap_no_val", b1.result_val, 1'b0);
        @(negedge clk);
        b1.c_data_in = ~c;
        for (int i = 0; i <= bp; i++) begin
            chk1("resp_val", b1.result_val, 1'b1);
            chk1("resp_ack_off", b1.block2host_rdy, 1'b0);
            chk1("resp_job_rdy", b1.job_rdy, 1'b0);
            chk1("resp_err", b1.result_err, 1'b0);
            chkw("resp_c", 256'(b1.result_c), 256'(c));
            chkw("resp_cycles", 256'(b1.result_cycles), 256'(exp_cyc));
            if (i < bp) @(negedge clk);
        end
        b1.result_rdy = 1'b1;
        @(negedge clk);
        b1.result_rdy = 1'b0;
        chk1("post_val_low", b1.result_val, 1'b0);
        chk1("post_job_rdy", b1.job_rdy, 1'b1);
        chkw("post_a_hold", 256'(b1.a_data_out), 256'(a));
    endtask

    initial begin
        logic seen_val;

        rst = 1'b1;
        b1.job_val = 1'b0; b1.job_a = '0; b1.job_b = '0;
        b1.host2block_rdy = 1'b0; b1.block2host_val = 1'b0;
        b1.c_data_in = '0; b1.result_rdy = 1'b0;
        b2.job_val = 1'b0; b2.job_a = '0; b2.job_b = '0;
        b2.host2block_rdy = 1'b0; b2.block2host_val = 1'b0;
        b2.c_data_in = '0; b2.result_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst");

        // Nominal: MAC ready one cycle after val, result 20 cycles later.
        run_job(A_ID, B_SEQ, C_SEQ, 1, 20, 0, 1'b0);
        // Backpressure: result_rdy held low for 10 cycles in RESP.
        run_job(128'h0123456789abcdef0011223344556677, 128'hfedcba98765432100f1e2d3c4b5a6978,
                256'h1111222233334444555566667777888899990000aaaabbbbccccddddeeeeffff, 0, 2, 10, 1'b0);

        // Back-to-back with job_val held high throughout.
        run_job(128'h11, 128'h22, 256'h33, 0, 3, 0, 1'b1);
        run_job(128'h44, 128'h55, 256'h66, 2, 0, 1, 1'b1);
        run_job(128'h77, 128'h88, 256'h99, 1, 5, 0, 1'b1);
        b1.job_val = 1'b0;
        @(negedge clk);
        chk1("b2b_no_extra_we", b1.a_b_we, 1'b0);
        chk1("b2b_idle", b1.job_rdy, 1'b1);
        chkw("b2b_last_a", 256'(b1.a_data_out), 256'h77);

        // Exit beats timeout: block2host_val in the cycle the wait count hits 7.
        b2.job_a = 128'hA2; b2.job_b = 128'hB2; b2.job_val = 1'b1;
        @(negedge clk);
        b2.job_val = 1'b0;
        @(negedge clk);
        b2.host2block_rdy = 1'b1;
        @(negedge clk);
        b2.host2block_rdy = 1'b0;
        repeat (7) @(negedge clk);
        chk1("sim_still_wait", b2.result_val, 1'b0);
        b2.block2host_val = 1'b1;
        @(negedge clk);
        b2.block2host_val = 1'b0;
        chk1("sim_read", b2.c_re, 1'b1);
        b2.c_data_in = 256'hC2C2;
        repeat (2) @(negedge clk);
        chk1("sim_val", b2.result_val, 1'b1);
        chk1("sim_err", b2.result_err, 1'b0);
        chkw("sim_c", 256'(b2.result_c), 256'hC2C2);
        chkw("sim_cycles", 256'(b2.result_cycles), 256'd12);
        b2.result_rdy = 1'b1;
        @(negedge clk);
        b2.result_rdy = 1'b0;
        b2.c_data_in = 256'hDEAD;

        // Timeout in REQ: host2block_rdy never comes, 8 REQ cycles then RESP.
        b2.job_a = 128'hA3; b2.job_b = 128'hB3; b2.job_val = 1'b1;
        @(negedge clk);
        b2.job_val = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            chk1("to_req_val", b2.host2block_val, 1'b1);
            @(negedge clk);
        end
        chk1("to_req_last", b2.host2block_val, 1'b1);
        chk1("to_not_yet", b2.result_val, 1'b0);
        @(negedge clk);
        chk1("to_val", b2.result_val, 1'b1);
        chk1("to_req_off", b2.host2block_val, 1'b0);
        chk1("to_err", b2.result_err, 1'b1);
        chkw("to_c_zero", 256'(b2.result_c), 256'd0);
        chkw("to_cycles", 256'(b2.result_cycles), 256'd9);
        b2.result_rdy = 1'b1;
        @(negedge clk);
        b2.result_rdy = 1'b0;

        // Following job, minimum latency, completes normally.
        chk1("after_to_rdy", b2.job_rdy, 1'b1);
        b2.job_a = 128'hA4; b2.job_b = 128'hB4; b2.job_val = 1'b1;
        @(negedge clk);
        b2.job_val = 1'b0;
        @(negedge clk);
        b2.host2block_rdy = 1'b1;
        @(negedge clk);
        b2.host2block_rdy = 1'b0;
        b2.block2host_val = 1'b1;
        @(negedge clk);
        b2.block2host_val = 1'b0;
        b2.c_data_in = 256'hC4C4;
        repeat (2) @(negedge clk);
        chk1("min_val", b2.result_val, 1'b1);
        chk1("min_err", b2.result_err, 1'b0);
        chkw("min_c", 256'(b2.result_c), 256'hC4C4);
        chkw("min_cycles", 256'(b2.result_cycles), 256'd5);
        b2.result_rdy = 1'b1;
        @(negedge clk);
        b2.result_rdy = 1'b0;

        // Reset for one cycle while in WAIT.
        b2.job_a = 128'hA5; b2.job_b = 128'hB5; b2.job_val = 1'b1;
        @(negedge clk);
        b2.job_val = 1'b0;
        @(negedge clk);
        b2.host2block_rdy = 1'b1;
        @(negedge clk);
        b2.host2block_rdy = 1'b0;
        chk1("mid_in_wait", b2.host2block_val, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        seen_val = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (b2.result_val !== 1'b0 || b2.a_b_we !== 1'b0) seen_val = 1'b1;
        end
        chk1("midrst_no_result", seen_val, 1'b0);
        chk1("midrst_idle", b2.job_rdy, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
